// File: rtl/pipeline_pkg.sv
// Shared definitions for the data-memory responder slice.
//   state_e     : responder FSM state encoding
//   WORD_W      : data word width
//   LATENCY_MAX : largest supported request-to-response latency
//   addr_err()  : misaligned / out-of-range check for a byte address
package pipeline_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Word accesses only: any low address bit set, or a word index past the
  // end of the array, is an error. The index is compared at full width so
  // large addresses never alias back into the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(depth));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage.
//   clk   : write clock
//   we    : write enable (synchronous)
//   idx   : word index for both read and write
//   wdata : write data
//   rdata : combinational read data at idx
// Contents start at zero and are deliberately not touched by reset.
module dmem_array
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned IDX_W       = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Handshaked, fixed-latency data memory seen by the MEM stage.
//   clk, clrn  : clock, asynchronous active-low reset
//   req_valid  : MEM stage presents a load/store
//   req_ready  : responder idle and able to accept
//   req_we     : 1 = store, 0 = load
//   req_addr   : byte address
//   req_wdata  : store data
//   rsp_valid  : one-cycle response pulse
//   rsp_rdata  : load data (0 for stores and errors), held until next response
//   rsp_err    : misaligned or out-of-range, qualified by rsp_valid
//   stall      : hold the pipeline while a request is in flight
// One request is outstanding at a time. A request accepted at edge N is
// performed at edge N+LATENCY, and the response is visible in the cycle after.
module dmem_responder
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(LATENCY_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [WORD_W-1:0]  wdata_q;
  logic [WORD_W-1:0]  rdata_q;
  logic               err_q;

  logic               accept;
  logic               access;
  logic               acc_err;
  logic               mem_we;
  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  arr_rdata;

  assign accept  = (state_q == IDLE) && req_valid;
  // With LATENCY=1 the counter loads 0, so the cycle after acceptance is
  // already the access cycle; no separate bypass path is needed.
  assign access  = (state_q == WAIT) && (cnt_q == '0);
  assign acc_err = addr_err(addr_q, DEPTH_WORDS);
  assign idx     = addr_q[IDX_W+1:2];
  assign mem_we  = access && we_q && !acc_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (idx),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request latch and response registers. The request is captured only on
  // acceptance so the MEM stage may change req_* freely while we wait.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (access) begin
        rdata_q <= (we_q || acc_err) ? '0 : arr_rdata;
        err_q   <= acc_err;
      end
    end
  end

  // Outputs.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = rsp_valid && err_q;
    // The pipeline advances in the response cycle itself.
    stall     = req_valid && !rsp_valid;
  end

endmodule
